// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT/TRAP mode FSM driving a registered PC
// with branch/jump selection, misalignment trap, optional auto-halt and a retire counter.
module pc_sequencer #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_004C,
    parameter bit          HALT_EN      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pc_target,
    input  logic             pc_src,
    input  logic             stall,
    input  logic [2:0]       cmd,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_4,
    output logic [1:0]       state,
    output logic             halted,
    output logic             trap,
    output logic [WIDTH-1:0] retired
);

    localparam logic [1:0] ST_IDLE = 2'h0;
    localparam logic [1:0] ST_RUN  = 2'h1;
    localparam logic [1:0] ST_HALT = 2'h2;
    localparam logic [1:0] ST_TRAP = 2'h3;

    localparam logic [2:0] CMD_START  = 3'h1;
    localparam logic [2:0] CMD_HALT   = 3'h2;
    localparam logic [2:0] CMD_RESUME = 3'h3;
    localparam logic [2:0] CMD_CLEAR  = 3'h4;

    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);
    localparam logic [WIDTH-1:0] HALT_PC = WIDTH'(HALT_ADDR);

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] retired_reg, retired_next;
    // Set on RESUME; suppresses the auto-halt match until the PC has moved on once.
    logic             skip_reg, skip_next;
    logic [WIDTH-1:0] next_pc;
    logic             misaligned;

    assign pc_plus_4  = pc_reg + WIDTH'(4);
    assign next_pc    = pc_src ? pc_target : pc_plus_4;
    assign misaligned = pc_src && (pc_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RST_PC;
            retired_reg <= '0;
            skip_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            retired_reg <= retired_next;
            skip_reg    <= skip_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        retired_next = retired_reg;
        skip_next    = skip_reg;
        case (state_reg)
            ST_IDLE: begin
                pc_next   = RST_PC;
                skip_next = 1'b0;
                if (cmd == CMD_START) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (misaligned) begin
                    state_next = ST_TRAP;
                    pc_next    = TRAP_PC;
                    skip_next  = 1'b0;
                end else if (cmd == CMD_HALT) begin
                    state_next = ST_HALT;
                end else if (HALT_EN && (pc_reg == HALT_PC) && !skip_reg) begin
                    state_next = ST_HALT;
                end else if (!stall) begin
                    pc_next      = next_pc;
                    retired_next = retired_reg + WIDTH'(1);
                    skip_next    = 1'b0;
                end
            end
            ST_HALT: begin
                if (cmd == CMD_RESUME) begin
                    state_next = ST_RUN;
                    skip_next  = 1'b1;
                end else if (cmd == CMD_CLEAR) begin
                    state_next = ST_IDLE;
                    pc_next    = RST_PC;
                    skip_next  = 1'b0;
                end
            end
            ST_TRAP: begin
                if (cmd == CMD_CLEAR) begin
                    state_next = ST_IDLE;
                    pc_next    = RST_PC;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pc_next    = RST_PC;
                skip_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state   = state_reg;
        pc      = pc_reg;
        retired = retired_reg;
        halted  = (state_reg == ST_HALT);
        trap    = (state_reg == ST_TRAP);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default 32-bit instance for the mode FSM
// and an 8-bit instance (auto-halt off) for pc/retired wrap-around.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_target;
    logic        pc_src;
    logic        stall;
    logic [2:0]  cmd;
    logic [31:0] pc, pc_plus_4, retired;
    logic [1:0]  state;
    logic        halted, trap;

    logic [7:0]  pc_target_b;
    logic        pc_src_b, stall_b;
    logic [2:0]  cmd_b;
    logic [7:0]  pc_b, pc_plus_4_b, retired_b;
    logic [1:0]  state_b;
    logic        halted_b, trap_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc_target(pc_target), .pc_src(pc_src),
        .stall(stall), .cmd(cmd), .pc(pc), .pc_plus_4(pc_plus_4),
        .state(state), .halted(halted), .trap(trap), .retired(retired)
    );

    pc_sequencer #(.WIDTH(8), .HALT_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .pc_target(pc_target_b), .pc_src(pc_src_b),
        .stall(stall_b), .cmd(cmd_b), .pc(pc_b), .pc_plus_4(pc_plus_4_b),
        .state(state_b), .halted(halted_b), .trap(trap_b), .retired(retired_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [1:0] st, input logic [31:0] p,
                           input logic [31:0] ret);
        check({tag, ".state"}, state, st);
        check({tag, ".pc"}, pc, p);
        check({tag, ".retired"}, retired, ret);
        check({tag, ".halted"}, halted, st == 2'h2);
        check({tag, ".trap"}, trap, st == 2'h3);
        $display("step %-14s state=%0d pc=0x%08h retired=%0d", tag, state, pc, retired);
    endtask

    initial begin
        logic [2:0] nops [4];
        nops[0] = 3'h0; nops[1] = 3'h5; nops[2] = 3'h6; nops[3] = 3'h7;
        rst_n = 1'b0; pc_target = '0; pc_src = 1'b0; stall = 1'b0; cmd = 3'h0;
        pc_target_b = '0; pc_src_b = 1'b0; stall_b = 1'b0; cmd_b = 3'h0;
        #2;

        // Reset state
        step();
        check_a("reset", 2'h0, 32'h0, 32'h0);
        check("reset.pc_plus_4", pc_plus_4, 32'h4);
        rst_n = 1'b1;

        // Sequential fetch
        cmd = 3'h1; step(); check_a("start", 2'h1, 32'h0, 32'h0);
        cmd = 3'h0;
        for (int i = 1; i <= 4; i++) begin
            step(); check_a("seq", 2'h1, 32'(4 * i), 32'(i));
        end

        // Jump then auto-halt at 0x4C
        pc_src = 1'b1; pc_target = 32'h40; step(); check_a("jump", 2'h1, 32'h40, 32'h5);
        pc_src = 1'b0;
        step(); check_a("seq44", 2'h1, 32'h44, 32'h6);
        step(); check_a("seq48", 2'h1, 32'h48, 32'h7);
        step(); check_a("seq4c", 2'h1, 32'h4C, 32'h8);
        step(); check_a("autohalt", 2'h2, 32'h4C, 32'h8);
        pc_src = 1'b1; pc_target = 32'h42; stall = 1'b1;
        step(); check_a("halt_ignore", 2'h2, 32'h4C, 32'h8);
        pc_src = 1'b0; stall = 1'b0;
        cmd = 3'h3; step(); check_a("resume", 2'h1, 32'h4C, 32'h8);
        cmd = 3'h0; step(); check_a("resume_adv", 2'h1, 32'h50, 32'h9);

        // Misaligned target beats stall and HALT
        pc_src = 1'b1; pc_target = 32'h42; stall = 1'b1; cmd = 3'h2;
        step(); check_a("trap", 2'h3, 32'h100, 32'h9);
        pc_src = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd = nops[i]; step(); check_a("trap_nop", 2'h3, 32'h100, 32'h9);
        end
        cmd = 3'h4; step(); check_a("trap_clear", 2'h0, 32'h0, 32'h9);

        // NOPs and non-START commands in IDLE
        for (int i = 0; i < 4; i++) begin
            cmd = nops[i]; step(); check_a("idle_nop", 2'h0, 32'h0, 32'h9);
        end
        cmd = 3'h2; step(); check_a("idle_halt", 2'h0, 32'h0, 32'h9);

        // Stall and NOPs in RUN, then manual halt and clear
        cmd = 3'h1; step(); check_a("start2", 2'h1, 32'h0, 32'h9);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd = nops[i]; step(); check_a("run_stall", 2'h1, 32'h0, 32'h9);
        end
        cmd = 3'h2; step(); check_a("man_halt", 2'h2, 32'h0, 32'h9);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd = nops[i]; step(); check_a("halt_nop", 2'h2, 32'h0, 32'h9);
        end
        cmd = 3'h4; step(); check_a("halt_clear", 2'h0, 32'h0, 32'h9);

        // Reset mid-RUN with stall and START
        cmd = 3'h1; step(); check_a("start3", 2'h1, 32'h0, 32'h9);
        cmd = 3'h0;
        step(); step(); check_a("run_adv", 2'h1, 32'h8, 32'hB);
        rst_n = 1'b0; stall = 1'b1; cmd = 3'h1;
        step(); check_a("rst_run", 2'h0, 32'h0, 32'h0);
        check("rst_run.pc_plus_4", pc_plus_4, 32'h4);
        rst_n = 1'b1; stall = 1'b0;

        // Reset while in TRAP
        step(); check_a("start4", 2'h1, 32'h0, 32'h0);
        cmd = 3'h0; pc_src = 1'b1; pc_target = 32'h3;
        step(); check_a("trap2", 2'h3, 32'h100, 32'h0);
        rst_n = 1'b0; pc_src = 1'b0;
        step(); check_a("rst_trap", 2'h0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // 8-bit instance: pc and retired wrap-around
        check("b.idle_state", state_b, 2'h0);
        cmd_b = 3'h1; step(); check("b.start_state", state_b, 2'h1);
        cmd_b = 3'h0;
        for (int i = 0; i < 63; i++) step();
        check("b.pc_fc", pc_b, 8'hFC);
        check("b.pc_plus_4_wrap", pc_plus_4_b, 8'h00);
        $display("step b_pc_fc pc=0x%02h pc_plus_4=0x%02h", pc_b, pc_plus_4_b);
        step();
        check("b.pc_wrap", pc_b, 8'h00);
        check("b.retired_64", retired_b, 8'd64);
        $display("step b_pc_wrap pc=0x%02h retired=%0d", pc_b, retired_b);
        for (int i = 0; i < 191; i++) step();
        check("b.retired_ff", retired_b, 8'hFF);
        step();
        check("b.retired_wrap", retired_b, 8'h00);
        check("b.state_run", state_b, 2'h1);
        $display("step b_ret_wrap retired=%0d", retired_b);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
